// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scan driver: one shared segment bus, one anode per digit,
// with a frame-synchronous display buffer, leading-zero blanking and blinking.
module seg7_scan_driver #(
  parameter int NUM_DIGITS     = 6,
  parameter int SCAN_DIV       = 50000,
  parameter int DEAD_CYCLES    = 500,
  parameter int BLINK_FRAMES   = 64,
  parameter int HEX_MODE       = 0,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    lzb_en,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start
);

  localparam int   PW      = $clog2(SCAN_DIV);
  localparam int   IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int   FW      = $clog2(BLINK_FRAMES + 1);
  localparam logic SEG_OFF = (SEG_ACTIVE_LOW != 0);
  localparam logic AN_OFF  = (AN_ACTIVE_LOW != 0);

  logic [PW-1:0] presc;
  logic [IW-1:0] idx;
  logic [FW-1:0] frame_cnt;
  logic          blink_ph;

  logic [4*NUM_DIGITS-1:0] sh_digits, disp_digits;
  logic [NUM_DIGITS-1:0]   sh_dp, disp_dp;
  logic [NUM_DIGITS-1:0]   sh_blank, disp_blank;
  logic [NUM_DIGITS-1:0]   sh_blink, disp_blink;
  logic                    sh_lzb, disp_lzb;

  logic          slot_end;
  logic          frame_end;
  logic          in_dead;
  logic [FW-1:0] frame_cnt_inc;

  // Per-digit lookup tables padded to a power of two so idx selects them exactly.
  logic [3:0]          code_arr [2**IW];
  logic [2**IW-1:0]    dark_pad;
  logic [2**IW-1:0]    dp_pad;
  logic [NUM_DIGITS-1:0] an_sel;
  logic                zero_run;

  assign slot_end      = (presc == PW'(SCAN_DIV - 1));
  assign frame_end     = slot_end && (idx == IW'(NUM_DIGITS - 1));
  assign in_dead       = int'(presc) < DEAD_CYCLES;
  assign frame_cnt_inc = frame_cnt + 1'b1;

  function automatic logic [6:0] glyph(input logic [3:0] code);
    logic [6:0] g;
    case (code)
      4'h0: g = 7'b0111111;
      4'h1: g = 7'b0000110;
      4'h2: g = 7'b1011011;
      4'h3: g = 7'b1001111;
      4'h4: g = 7'b1100110;
      4'h5: g = 7'b1101101;
      4'h6: g = 7'b1111101;
      4'h7: g = 7'b0000111;
      4'h8: g = 7'b1111111;
      4'h9: g = 7'b1101111;
      4'hA: g = (HEX_MODE != 0) ? 7'b1110111 : 7'b0000000;
      4'hB: g = (HEX_MODE != 0) ? 7'b1111100 : 7'b0000000;
      4'hC: g = (HEX_MODE != 0) ? 7'b0111001 : 7'b0000000;
      4'hD: g = (HEX_MODE != 0) ? 7'b1011110 : 7'b0000000;
      4'hE: g = (HEX_MODE != 0) ? 7'b1111001 : 7'b0000000;
      default: g = (HEX_MODE != 0) ? 7'b1110001 : 7'b0000000;
    endcase
    return g;
  endfunction

  // Walk from the most significant digit down: a digit is a leading zero while
  // every code at or above it is zero. Digit 0 always shows.
  always_comb begin
    zero_run = 1'b1;
    dark_pad = '0;
    dp_pad   = '0;
    an_sel   = '0;
    for (int j = 0; j < 2**IW; j++) begin
      code_arr[j] = 4'd0;
    end
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run    = zero_run && (disp_digits[4*k +: 4] == 4'd0);
      code_arr[k] = disp_digits[4*k +: 4];
      dark_pad[k] = disp_blank[k] || (disp_blink[k] && blink_ph) ||
                    (disp_lzb && zero_run && (k != 0));
      dp_pad[k]   = disp_dp[k];
      an_sel[k]   = (idx == IW'(k)) && !in_dead;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc       <= '0;
      idx         <= '0;
      frame_cnt   <= '0;
      blink_ph    <= 1'b0;
      sh_digits   <= '0;
      sh_dp       <= '0;
      sh_blank    <= '0;
      sh_blink    <= '0;
      sh_lzb      <= 1'b0;
      disp_digits <= '0;
      disp_dp     <= '0;
      disp_blank  <= '0;
      disp_blink  <= '0;
      disp_lzb    <= 1'b0;
      seg         <= {7{SEG_OFF}};
      dp          <= SEG_OFF;
      an          <= {NUM_DIGITS{AN_OFF}};
      frame_start <= 1'b0;
    end else begin
      presc <= slot_end ? '0 : presc + 1'b1;
      if (slot_end) begin
        idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
      end
      frame_start <= frame_end;
      // Display swaps only at the frame boundary so a frame never mixes two loads.
      if (frame_end) begin
        disp_digits <= sh_digits;
        disp_dp     <= sh_dp;
        disp_blank  <= sh_blank;
        disp_blink  <= sh_blink;
        disp_lzb    <= sh_lzb;
        if (frame_cnt_inc == FW'(BLINK_FRAMES)) begin
          frame_cnt <= '0;
          blink_ph  <= ~blink_ph;
        end else begin
          frame_cnt <= frame_cnt_inc;
        end
      end
      if (load) begin
        sh_digits <= digits;
        sh_dp     <= dp_in;
        sh_blank  <= blank_mask;
        sh_blink  <= blink_mask;
        sh_lzb    <= lzb_en;
      end
      seg <= {7{SEG_OFF}} ^ (dark_pad[idx] ? 7'b0000000 : glyph(code_arr[idx]));
      dp  <= SEG_OFF ^ (dp_pad[idx] && !dark_pad[idx]);
      an  <= {NUM_DIGITS{AN_OFF}} ^ an_sel;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: two instances (HEX_MODE 0 and 1) share stimulus;
// expected outputs are queued per cycle and popped by an independent monitor.
module tb_seg7_scan_driver;

  localparam logic [6:0] Z0 = 7'b1000000;
  localparam logic [6:0] D1 = 7'b1111001;
  localparam logic [6:0] D2 = 7'b0100100;
  localparam logic [6:0] D3 = 7'b0110000;
  localparam logic [6:0] D4 = 7'b0011001;
  localparam logic [6:0] D7 = 7'b1111000;
  localparam logic [6:0] DK = 7'b1111111;
  localparam logic [6:0] HA = 7'b0001000;
  localparam logic [6:0] HB = 7'b0000011;
  localparam logic [27:0] ALLZ = {Z0, Z0, Z0, Z0};

  typedef struct packed {
    logic [31:0] cyc;
    logic [3:0]  an;
    logic [6:0]  seg0;
    logic [6:0]  seg1;
    logic        dp;
    logic        fs;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] digits = '0;
  logic [3:0]  dp_in = '0, blank_mask = '0, blink_mask = '0;
  logic        lzb_en = 1'b0, load = 1'b0;
  logic [6:0]  seg0, seg1;
  logic        dp0, dp1, fs0, fs1;
  logic [3:0]  an0, an1;

  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc;
  int   checks = 0;
  int   errors = 0;

  seg7_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4), .DEAD_CYCLES(1), .BLINK_FRAMES(2),
    .HEX_MODE(0), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) u_dec (
    .clk(clk), .rst_n(rst_n), .digits(digits), .dp_in(dp_in), .blank_mask(blank_mask),
    .blink_mask(blink_mask), .lzb_en(lzb_en), .load(load),
    .seg(seg0), .dp(dp0), .an(an0), .frame_start(fs0));

  seg7_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4), .DEAD_CYCLES(1), .BLINK_FRAMES(2),
    .HEX_MODE(1), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) u_hex (
    .clk(clk), .rst_n(rst_n), .digits(digits), .dp_in(dp_in), .blank_mask(blank_mask),
    .blink_mask(blink_mask), .lzb_en(lzb_en), .load(load),
    .seg(seg1), .dp(dp1), .an(an1), .frame_start(fs1));

  // Clock and cycle count since reset release.
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string name, input int c, input logic [6:0] act, input logic [6:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%b want=%b", name, c, act, want);
    end
  endtask

  // Monitor: compare every queued expectation on the cycle it names.
  always @(negedge clk) begin
    if (rst_n) begin
      while (exp_q.size() > 0 && int'(exp_q[0].cyc) <= cyc) begin
        mon_e = exp_q.pop_front();
        if (int'(mon_e.cyc) != cyc) begin
          checks++;
          errors++;
          $display("FAIL missed_entry cyc=%0d got=none want=cyc%0d", cyc, mon_e.cyc);
        end else begin
          chk("an_dec",  cyc, 7'(an0), 7'(mon_e.an));
          chk("an_hex",  cyc, 7'(an1), 7'(mon_e.an));
          chk("seg_dec", cyc, seg0, mon_e.seg0);
          chk("seg_hex", cyc, seg1, mon_e.seg1);
          chk("dp_dec",  cyc, 7'(dp0), 7'(mon_e.dp));
          chk("dp_hex",  cyc, 7'(dp1), 7'(mon_e.dp));
          chk("fs_dec",  cyc, 7'(fs0), 7'(mon_e.fs));
          chk("fs_hex",  cyc, 7'(fs1), 7'(mon_e.fs));
        end
      end
    end
  end

  // Frame f, slot s occupies cycles 16f+4s+1 .. 16f+4s+4; the first is the dead cycle.
  task automatic push_frame(input int f, input int s_lo, input int s_hi,
                            input logic [27:0] segs0, input logic [27:0] segs1,
                            input logic [3:0] dps);
    exp_t e;
    logic [3:0] one;
    one = 4'b0001;
    for (int s = s_lo; s <= s_hi; s++) begin
      for (int j = 0; j < 4; j++) begin
        e.cyc  = 32'(16*f + 4*s + j + 1);
        e.an   = (j == 0) ? 4'b1111 : ~(one << s);
        e.seg0 = segs0[7*s +: 7];
        e.seg1 = segs1[7*s +: 7];
        e.dp   = dps[s];
        e.fs   = (s == 3) && (j == 3);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_an_dec",  0, 7'(an0), 7'b0001111);
    chk("rst_an_hex",  0, 7'(an1), 7'b0001111);
    chk("rst_seg_dec", 0, seg0, 7'b1111111);
    chk("rst_seg_hex", 0, seg1, 7'b1111111);
    chk("rst_dp",      0, 7'(dp0), 7'd1);
    chk("rst_fs",      0, 7'(fs0), 7'd0);
    // A load strobe during reset must leave the shadow cleared.
    digits = 16'h8888; dp_in = 4'hF; load = 1'b1;
    repeat (2) @(negedge clk);
    load = 1'b0; digits = '0; dp_in = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_cyc(input int n);
    int g;
    g = 0;
    while (cyc != n && g < 2000) begin
      @(negedge clk);
      g++;
    end
    checks++;
    if (cyc != n) begin
      errors++;
      $display("FAIL wait_cyc got=%0d want=%0d", cyc, n);
    end
  endtask

  task automatic load_vals(input logic [15:0] d, input logic [3:0] dpv,
                           input logic [3:0] bl, input logic [3:0] bk, input logic lz);
    digits = d; dp_in = dpv; blank_mask = bl; blink_mask = bk; lzb_en = lz;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_empty();
    int g;
    g = 0;
    while (exp_q.size() > 0 && g < 300) begin
      @(negedge clk);
      g++;
    end
    checks++;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain_timeout got=%0d want=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    // Reset release with no load: zeros scanned, dead cycle per slot, frame_start every 16.
    do_reset();
    push_frame(0, 0, 3, ALLZ, ALLZ, 4'hF);
    push_frame(1, 0, 3, ALLZ, ALLZ, 4'hF);
    wait_empty();

    // Mid-frame load shows only from the next frame.
    do_reset();
    push_frame(0, 0, 3, ALLZ, ALLZ, 4'hF);
    push_frame(1, 0, 3, {D1, D2, D3, D4}, {D1, D2, D3, D4}, 4'hF);
    wait_cyc(5);
    load_vals(16'h1234, 4'h0, 4'h0, 4'h0, 1'b0);
    wait_empty();

    // Load on the boundary cycle appears one frame later.
    do_reset();
    push_frame(0, 0, 3, ALLZ, ALLZ, 4'hF);
    push_frame(1, 0, 3, ALLZ, ALLZ, 4'hF);
    push_frame(2, 0, 3, {D1, D2, D3, D4}, {D1, D2, D3, D4}, 4'hF);
    wait_cyc(15);
    load_vals(16'h1234, 4'h0, 4'h0, 4'h0, 1'b0);
    wait_empty();

    // Leading-zero blanking keeps digit 0.
    do_reset();
    push_frame(0, 0, 3, ALLZ, ALLZ, 4'hF);
    push_frame(1, 0, 3, {DK, DK, D7, Z0}, {DK, DK, D7, Z0}, 4'hF);
    wait_cyc(2);
    load_vals(16'h0070, 4'h0, 4'h0, 4'h0, 1'b1);
    wait_empty();

    // Codes A/B: dark without hex glyphs, A and b with them.
    do_reset();
    push_frame(0, 0, 3, ALLZ, ALLZ, 4'hF);
    push_frame(1, 0, 3, {Z0, Z0, DK, DK}, {Z0, Z0, HA, HB}, 4'hF);
    wait_cyc(2);
    load_vals(16'h00AB, 4'h0, 4'h0, 4'h0, 1'b0);
    wait_empty();

    // Blink: digit 0 with dp lit two frames, dark two frames, lit again.
    do_reset();
    push_frame(0, 0, 3, ALLZ, ALLZ, 4'hF);
    push_frame(1, 0, 3, ALLZ, ALLZ, 4'b1110);
    push_frame(2, 0, 3, {Z0, Z0, Z0, DK}, {Z0, Z0, Z0, DK}, 4'b1111);
    push_frame(3, 0, 3, {Z0, Z0, Z0, DK}, {Z0, Z0, Z0, DK}, 4'b1111);
    push_frame(4, 0, 3, ALLZ, ALLZ, 4'b1110);
    wait_cyc(2);
    load_vals(16'h0000, 4'b0001, 4'h0, 4'b0001, 1'b0);
    wait_empty();

    // Reset during slot 2 forces outputs dark; restart from slot 0 with display cleared.
    do_reset();
    push_frame(0, 0, 3, ALLZ, ALLZ, 4'hF);
    push_frame(1, 0, 1, {D1, D2, D3, D4}, {D1, D2, D3, D4}, 4'hF);
    wait_cyc(2);
    load_vals(16'h1234, 4'h0, 4'h0, 4'h0, 1'b0);
    wait_cyc(26);
    wait_empty();
    do_reset();
    push_frame(0, 0, 3, ALLZ, ALLZ, 4'hF);
    push_frame(1, 0, 3, ALLZ, ALLZ, 4'hF);
    wait_empty();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Parametrised multiplexed 7-segment display driver for the clock's display subsystem. It accepts NUM_DIGITS packed BCD/hex digits plus per-digit decimal-point, blank and blink masks, and time-multiplexes them onto one shared segment bus with one anode per digit. It adds the following beyond a single-digit decoder:
- scan timing with anti-ghosting dead time
- frame-synchronous double buffering (no tearing)
- leading-zero blanking
- blinking
- selectable hex glyphs
- selectable output polarity

Parameters:
NUM_DIGITS, 6, number of multiplexed digits (1..16)
SCAN_DIV, 50000, clk cycles per digit slot (>=2)
DEAD_CYCLES, 500, cycles at slot start with all anodes inactive (0..SCAN_DIV-1)
BLINK_FRAMES, 64, full scan frames per blink half-period (>=1)
HEX_MODE, 0, 1: codes 10..15 show A,b,C,d,E,F; 0: codes 10..15 blank
SEG_ACTIVE_LOW, 1, 1: seg and dp are driven low to light
AN_ACTIVE_LOW, 1, 1: an is driven low to select a digit

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
digits  input  4*NUM_DIGITS  packed codes; digit k = digits[4k+3:4k], k=0 is rightmost/least significant
dp_in  input  NUM_DIGITS  decimal point per digit
blank_mask  input  NUM_DIGITS  1 = force digit dark
blink_mask  input  NUM_DIGITS  1 = digit dark during blink-off phase
lzb_en  input  1  leading-zero blanking enable
load  input  1  1-cycle strobe: capture digits/dp_in/blank_mask/blink_mask/lzb_en into shadow register
seg  output  7  segments {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
dp  output  1  decimal point, polarity per SEG_ACTIVE_LOW
an  output  NUM_DIGITS  digit enables, polarity per AN_ACTIVE_LOW
frame_start  output  1  1-cycle pulse when digit 0 slot begins

Behaviour:
Reset (rst_n low, async):
- presc=0, idx=0, frame_cnt=0, blink_ph=0.
- Shadow and display registers cleared to 0 (all masks 0, lzb_en 0).
- seg, dp, an all inactive; frame_start=0.

Scan timing:
- presc counts 0..SCAN_DIV-1 and wraps.
- On wrap, idx increments 0..NUM_DIGITS-1 and wraps to 0.
- Frame boundary = cycle where presc==SCAN_DIV-1 and idx==NUM_DIGITS-1. On the next edge:
  - display <= shadow
  - frame_start=1 for one cycle
  - frame_cnt increments; when it reaches BLINK_FRAMES it resets to 0 and blink_ph toggles.

Outputs:
- All outputs are registered, computed from the current presc/idx/display.
- an bit idx is active only when presc >= DEAD_CYCLES; otherwise all anodes are inactive.
- seg and dp are driven for idx throughout the slot.

Glyphs (active-high gfedcba):
- 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111.
- HEX_MODE=1: A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001.
- HEX_MODE=0: codes 10..15 produce all segments off.
- When SEG_ACTIVE_LOW=1, the output is the bitwise inverse.

Dark digit (segments and dp inactive, anode still scanned) when any of:
- blank_mask[k]
- blink_mask[k] and blink_ph=1
- LZB: lzb_en=1, digit k==0, and all digits above k==0. Digit 0 is never LZB-blanked.
- LZB considers digit codes only, not blank or dp.

Load:
- load at edge t: shadow updated at t+1; visible from the next frame boundary.
- load on the frame-boundary cycle: display takes the old shadow; the new value appears one frame later.
- load while rst_n low: ignored.

Wrap and reset:
- idx wrap with NUM_DIGITS=1 means every slot is a frame boundary.
- Reset mid-frame immediately forces outputs inactive; scanning restarts at idx 0 with a full dead time.

Test Plan:
All cases use NUM_DIGITS=4, SCAN_DIV=4, DEAD_CYCLES=1, BLINK_FRAMES=2, HEX_MODE=0, both polarities active-low.
- Reset release, no load -> an:
  - cycle 1 after release: 1111
  - cycles 2-4: 1110
  - then 1111 then 1101
  - seg=1000000 (digit 0, "0") during slot 0.
  - frame_start pulses every 16 cycles.
- load digits=16'h1234 mid-frame -> display still 0000 until frame_start. Next frame: slot 0 seg=0011001 (4), slot 3 seg=1111001 (1).
- load digits=16'h0070, lzb_en=1 -> slots 3 and 2 seg=1111111 (dark), slot 1 seg=1111000 (7), slot 0 seg=1000000 (0 kept).
- load digits=16'h00AB, HEX_MODE=0 -> slots 0,1 seg=1111111; rerun with HEX_MODE=1 -> slot 0 seg=0000011 (b), slot 1 seg=0001000 (A).
- blink_mask=4'b0001, dp_in=4'b0001 -> slot 0 lit (dp=0) for 2 frames, dark (seg=1111111, dp=1) for 2 frames, repeating; an keeps scanning.
- Assert rst_n low during slot 2 -> an=1111 and seg=1111111 asynchronously. After release, scan resumes at slot 0 with a dead cycle and display=0.
